eth_header_arbiter: RTL
=======================

ETH_HEADER_ARBITER -- requirements
Module: eth_header_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of header requesters; legal range 2..8.
REQ-002 Parameter SEL_W, default $clog2(N_PORTS), width of the grant index output.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  N_PORTS  per-requester header valid.
REQ-006 s_ready  output  N_PORTS  per-requester header accepted this cycle.
REQ-007 s_src_mac  input  N_PORTS*48  requester source MACs; port i at bits [48*i+47:48*i].
REQ-008 s_dest_mac  input  N_PORTS*48  requester destination MACs; same packing.
REQ-009 s_type  input  N_PORTS*16  requester EtherTypes; port i at [16*i+15:16*i].
REQ-010 m_valid  output  1  output header valid.
REQ-011 m_ready  input  1  downstream accepts output header.
REQ-012 m_src_mac  output  48  selected source MAC.
REQ-013 m_dest_mac  output  48  selected destination MAC (full 48 bits).
REQ-014 m_type  output  16  selected EtherType.
REQ-015 m_sel  output  SEL_W  index of the requester whose header is on m_*.

Function
REQ-016 Transfer on any side occurs when valid and ready are both high at a rising edge; valid/ready semantics are AXI-Stream-like.
REQ-017 Block holds one output register (m_valid, m_src_mac, m_dest_mac, m_type, m_sel); register is "free" when m_valid=0 or m_ready=1.
REQ-018 Grant: round-robin over asserted s_valid, searching from index ptr upward with wrap-around from N_PORTS-1 to 0; first asserted index wins.
REQ-019 s_ready[g]=1 only for winning index g and only while register is free; all other s_ready bits 0; s_ready all 0 when no s_valid.
REQ-020 s_ready depends combinationally on s_valid, ptr, m_valid, m_ready; at most one s_ready bit high per cycle.
REQ-021 On accept from port g: output register loads port g fields, m_sel<=g, m_valid<=1 next cycle (latency 1 cycle); ptr<=(g+1) mod N_PORTS.
REQ-022 Output fields and m_sel SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 On m_ready=1 with m_valid=1 and no new accept: m_valid<=0 next cycle.
REQ-024 Simultaneous output drain and new accept in one cycle: register reloads, m_valid stays 1; sustained throughput one header per cycle.
REQ-025 ptr SHALL not change on cycles with no accept.
REQ-026 Fairness: with all ports continuously valid, each port is granted exactly once in every N_PORTS consecutive accepts.
REQ-027 Requester dropping s_valid before being granted loses no state; no grant is remembered.
REQ-028 m_ready with m_valid=0 is ignored.

Reset
REQ-029 While rst=1 at a clock edge: m_valid<=0, ptr<=0, m_sel<=0, m_src_mac<=0, m_dest_mac<=0, m_type<=0.
REQ-030 While rst=1, s_ready SHALL be all 0 and no accept occurs.
REQ-031 Reset mid-transfer discards any held header; first cycle after rst deassertion arbitrates from ptr=0.

Verification
REQ-032 Single: after reset, port 2 valid with src=02:00:00:00:00:02, dest=FF:FF:FF:FF:FF:FF, type=0x0800, m_ready=1 -> s_ready=4'b0100 in same cycle; next cycle m_valid=1, m_sel=2, fields match; following cycle m_valid=0.
REQ-033 Round-robin: all 4 ports valid continuously, m_ready=1 -> m_sel sequence 0,1,2,3,0,1 on consecutive cycles, m_valid held 1.
REQ-034 Backpressure: port 1 accepted, m_ready=0 for 5 cycles while port 3 valid -> s_ready=0 for all 5 cycles, m_* stable with m_sel=1; on m_ready=1 port 3 accepted same cycle, m_sel=3 next cycle.
REQ-035 Wrap: ptr=3 (after granting port 2), ports 0 and 1 valid, port 3 idle -> port 0 granted, then port 1.
REQ-036 Reset mid-op: m_valid=1 with m_ready=0, assert rst one cycle -> m_valid=0, s_ready=0 during rst; after release with ports 1 and 3 valid, port 1 granted first.
REQ-037 Sparse: ports 0 and 3 alternate single-cycle valids with m_ready random 50% -> every header appears on m_* exactly once, in acceptance order, with correct m_sel; no duplicates or drops.

Source files
------------

// File: rtl/eth_header_arbiter_if.sv
// eth_header_arbiter_if: header request/response bundle between N_PORTS requesters, the arbiter and downstream.
// s_valid/s_ready/s_src_mac/s_dest_mac/s_type: requester side, port i packed at [48*i +: 48] / [16*i +: 16].
// m_valid/m_ready/m_src_mac/m_dest_mac/m_type/m_sel: arbitrated output header and the index of its source.
interface eth_header_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int SEL_W   = $clog2(N_PORTS)
);
    logic [N_PORTS-1:0]    s_valid;
    logic [N_PORTS-1:0]    s_ready;
    logic [N_PORTS*48-1:0] s_src_mac;
    logic [N_PORTS*48-1:0] s_dest_mac;
    logic [N_PORTS*16-1:0] s_type;
    logic                  m_valid;
    logic                  m_ready;
    logic [47:0]           m_src_mac;
    logic [47:0]           m_dest_mac;
    logic [15:0]           m_type;
    logic [SEL_W-1:0]      m_sel;

    modport master (
        output s_valid, s_src_mac, s_dest_mac, s_type, m_ready,
        input  s_ready, m_valid, m_src_mac, m_dest_mac, m_type, m_sel
    );

    modport slave (
        input  s_valid, s_src_mac, s_dest_mac, s_type, m_ready,
        output s_ready, m_valid, m_src_mac, m_dest_mac, m_type, m_sel
    );
endinterface

// File: rtl/eth_header_arbiter.sv
// eth_header_arbiter: round-robin merge of N_PORTS Ethernet header streams into one registered output.
// clk/rst: rising-edge clock, synchronous active-high reset.
// bus (slave): s_* requester handshakes and fields in, m_* single output header register out.
module eth_header_arbiter #(
    parameter int N_PORTS = 4,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input logic               clk,
    input logic               rst,
    eth_header_arbiter_if.slave bus
);
    logic             m_valid_q, m_valid_d;
    logic [47:0]      src_q, src_d, dest_q, dest_d;
    logic [15:0]      type_q, type_d;
    logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, g;
    logic             found, accept;

    // Lowest valid index overall is the wrap-around fallback; the lowest valid index at or above ptr overrides it.
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (bus.s_valid[i]) begin
                found = 1'b1;
                g     = SEL_W'(i);
            end
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (bus.s_valid[i] && i >= int'(ptr_q)) g = SEL_W'(i);
    end

    always_comb begin
        accept      = found && (!m_valid_q || bus.m_ready) && !rst;
        bus.s_ready = accept ? {{(N_PORTS-1){1'b0}}, 1'b1} << g : '0;
        m_valid_d   = accept || (m_valid_q && !bus.m_ready);
        src_d       = accept ? bus.s_src_mac[48*g +: 48] : src_q;
        dest_d      = accept ? bus.s_dest_mac[48*g +: 48] : dest_q;
        type_d      = accept ? bus.s_type[16*g +: 16] : type_q;
        sel_d       = accept ? g : sel_q;
        ptr_d       = accept ? ((g == SEL_W'(N_PORTS - 1)) ? '0 : g + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            src_q     <= '0;
            dest_q    <= '0;
            type_q    <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            type_q    <= type_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.m_valid    = m_valid_q;
    assign bus.m_src_mac  = src_q;
    assign bus.m_dest_mac = dest_q;
    assign bus.m_type     = type_q;
    assign bus.m_sel      = sel_q;
endmodule
